bj_resolve_btb: RTL

ID-stage branch/jump resolution unit with a built-in branch target buffer (BTB) that serves fetch-side prediction. The BTB is direct-mapped and parametrised, with 2-bit saturating counters. The ID side resolves the same one-hot bj_type_ID encoding as Branch_Jump_ID, produces the link address, and flags a misprediction with a redirect PC. Two 32-bit performance counters track resolved branches and mispredictions.

---
 rtl/bj_resolve_btb_if.sv | 43 ++++
 rtl/bj_resolve_btb.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bj_resolve_btb_if.sv
// Fetch-side BTB lookup and ID-side branch resolution signal bundle.
// The master side drives fetch PC and ID operands; the slave side answers with predictions/resolution.
// No handshake: every field is valid each cycle and is qualified by id_valid / id_stall.
interface bj_resolve_btb_if;
  // Fetch lookup
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  // ID resolution inputs
  logic        id_valid;
  logic        id_stall;
  logic [9:0]  bj_type_ID;
  logic [31:0] num_a_ID;
  logic [31:0] num_b_ID;
  logic [15:0] imm_b_ID;
  logic [25:0] imm_j_ID;
  logic [31:0] JR_addr_ID;
  logic [31:0] PC_ID;
  logic        pred_taken_ID;
  logic [31:0] pred_target_ID;
  // ID resolution outputs
  logic        Branch_Jump;
  logic [31:0] BJ_address;
  logic [31:0] link_addr;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] cnt_branch;
  logic [31:0] cnt_mispred;

  modport master (
    output if_pc, id_valid, id_stall, bj_type_ID, num_a_ID, num_b_ID, imm_b_ID,
           imm_j_ID, JR_addr_ID, PC_ID, pred_taken_ID, pred_target_ID,
    input  if_pred_taken, if_pred_target, Branch_Jump, BJ_address, link_addr,
           mispredict, redirect_pc, cnt_branch, cnt_mispred
  );

  modport slave (
    input  if_pc, id_valid, id_stall, bj_type_ID, num_a_ID, num_b_ID, imm_b_ID,
           imm_j_ID, JR_addr_ID, PC_ID, pred_taken_ID, pred_target_ID,
    output if_pred_taken, if_pred_target, Branch_Jump, BJ_address, link_addr,
           mispredict, redirect_pc, cnt_branch, cnt_mispred
  );
endinterface

// File: rtl/bj_resolve_btb.sv
// ID-stage branch/jump resolver with a direct-mapped BTB (2-bit counters) and perf counters.
// Latency: resolution and lookup are combinational; table/counter updates land at the next edge.
// Backpressure: id_stall blocks table and counter updates; mispredict is still reported while stalled.
module bj_resolve_btb #(
  parameter int         BTB_ENTRIES     = 16,
  parameter int         TAG_W           = 10,
  parameter logic [1:0] CTR_ALLOC_TAKEN = 2'b10,
  parameter bit         PERF_EN         = 1'b1
) (
  input logic              clk,
  input logic              rst,
  bj_resolve_btb_if.slave  bus
);
  localparam int IDX_W  = $clog2(BTB_ENTRIES);
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = TAG_LO + TAG_W - 1;

  // Table storage; async read so it maps to flops or distributed RAM
  logic             tbl_valid  [BTB_ENTRIES];
  logic [1:0]       tbl_ctr    [BTB_ENTRIES];
  logic [TAG_W-1:0] tbl_tag    [BTB_ENTRIES];
  logic [31:0]      tbl_target [BTB_ENTRIES];

  // ---------------- Resolution ----------------
  logic [9:0]  ty;
  logic        type_onehot;
  logic        is_bj;
  logic        is_jump;
  logic [31:0] a;
  logic        a_neg;
  logic        a_zero;
  logic        a_eq_b;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus8;
  logic [31:0] br_target;
  logic        bj_taken;
  logic [31:0] bj_addr;

  assign ty          = bus.bj_type_ID;
  assign type_onehot = (ty != 10'd0) && ((ty & (ty - 10'd1)) == 10'd0);
  assign is_bj       = bus.id_valid & type_onehot;
  assign is_jump     = ty[8] | ty[9];
  assign a           = bus.num_a_ID;
  assign a_neg       = a[31];
  assign a_zero      = (a == 32'd0);
  assign a_eq_b      = (a == bus.num_b_ID);
  assign pc_plus4    = bus.PC_ID + 32'd4;
  assign pc_plus8    = bus.PC_ID + 32'd8;
  assign br_target   = pc_plus4 + {{14{bus.imm_b_ID[15]}}, bus.imm_b_ID, 2'b00};

  // Decode the one-hot type into taken/target; anything not one-hot falls through as sequential
  always_comb begin
    bj_taken = 1'b0;
    bj_addr  = pc_plus4;
    if (type_onehot) begin
      if (|ty[7:0])       bj_addr  = br_target;
      if (ty[0])          bj_taken = a_eq_b;
      if (ty[1])          bj_taken = !a_eq_b;
      if (ty[2] | ty[7])  bj_taken = !a_neg;
      if (ty[3])          bj_taken = !a_neg & !a_zero;
      if (ty[4])          bj_taken = a_neg | a_zero;
      if (ty[5] | ty[6])  bj_taken = a_neg;
      if (ty[8]) begin
        bj_taken = 1'b1;
        bj_addr  = {bus.PC_ID[31:28], bus.imm_j_ID, 2'b00};
      end
      if (ty[9]) begin
        bj_taken = 1'b1;
        bj_addr  = bus.JR_addr_ID;
      end
    end
  end

  assign bus.Branch_Jump = bj_taken;
  assign bus.BJ_address  = bj_addr;
  assign bus.link_addr   = pc_plus8;

  // ---------------- Misprediction ----------------
  logic        mp;
  logic [31:0] rpc;

  // Not-taken redirects skip past the delay slot, which fetch always brings in
  always_comb begin
    mp  = 1'b0;
    rpc = pc_plus4;
    if (is_bj) begin
      mp  = (bus.pred_taken_ID != bj_taken) |
            (bj_taken & (bus.pred_target_ID != bj_addr));
      rpc = bj_taken ? bj_addr : pc_plus8;
    end else if (bus.id_valid & bus.pred_taken_ID) begin
      // BTB aliased a non-branch into a taken prediction
      mp  = 1'b1;
      rpc = pc_plus4;
    end
    if (rst) mp = 1'b0;
  end

  assign bus.mispredict  = mp;
  assign bus.redirect_pc = rpc;

  // ---------------- Fetch lookup ----------------
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  assign if_idx = bus.if_pc[IDX_W+1:2];
  assign if_tag = bus.if_pc[TAG_HI:TAG_LO];
  assign if_hit = tbl_valid[if_idx] && (tbl_tag[if_idx] == if_tag);

  assign bus.if_pred_taken  = if_hit & tbl_ctr[if_idx][1];
  assign bus.if_pred_target = bus.if_pred_taken ? tbl_target[if_idx] : 32'd0;

  // ---------------- Table update ----------------
  logic [IDX_W-1:0] id_idx;
  logic [TAG_W-1:0] id_tag;
  logic             id_hit;
  logic             upd_en;

  assign id_idx = bus.PC_ID[IDX_W+1:2];
  assign id_tag = bus.PC_ID[TAG_HI:TAG_LO];
  assign id_hit = tbl_valid[id_idx] && (tbl_tag[id_idx] == id_tag);
  assign upd_en = bus.id_valid & !bus.id_stall;

  // Train the entry addressed by PC_ID; a lookup in the same cycle sees the old contents
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tbl_valid[i] <= 1'b0;
        tbl_ctr[i]   <= 2'b01;
      end
    end else if (upd_en) begin
      if (is_bj && id_hit) begin
        if (is_jump) begin
          tbl_ctr[id_idx]    <= 2'b11;
          tbl_target[id_idx] <= bj_addr;
        end else if (bj_taken) begin
          if (tbl_ctr[id_idx] != 2'b11) tbl_ctr[id_idx] <= tbl_ctr[id_idx] + 2'd1;
          tbl_target[id_idx] <= bj_addr;
        end else begin
          if (tbl_ctr[id_idx] != 2'b00) tbl_ctr[id_idx] <= tbl_ctr[id_idx] - 2'd1;
        end
      end else if (is_bj && bj_taken) begin
        tbl_valid[id_idx]  <= 1'b1;
        tbl_tag[id_idx]    <= id_tag;
        tbl_target[id_idx] <= bj_addr;
        tbl_ctr[id_idx]    <= is_jump ? 2'b11 : CTR_ALLOC_TAKEN;
      end else if (!is_bj && bus.pred_taken_ID && id_hit) begin
        tbl_valid[id_idx] <= 1'b0;
      end
    end
  end

  // ---------------- Performance counters ----------------
  logic [31:0] cnt_br_q;
  logic [31:0] cnt_mp_q;

  // Count resolved branches and redirects on the same condition that trains the table
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_br_q <= 32'd0;
      cnt_mp_q <= 32'd0;
    end else if (PERF_EN && upd_en) begin
      if (is_bj) cnt_br_q <= cnt_br_q + 32'd1;
      if (mp)    cnt_mp_q <= cnt_mp_q + 32'd1;
    end
  end

  assign bus.cnt_branch  = cnt_br_q;
  assign bus.cnt_mispred = cnt_mp_q;

  // PC bits outside index/tag fields carry no information for the table
  logic unused_ok;
  assign unused_ok = ^{bus.if_pc, bus.PC_ID};

endmodule
